// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Boot-time image loader that sits in front of pl_riscv_cpu. It receives a
// framed byte stream, assembles little-endian 32-bit words, writes them through
// the top's external memory-write port and holds the CPU in reset until the
// whole image has been written and its XOR checksum has matched.
//
// Frame: N[7:0], N[15:8], N*4 payload bytes (LE words), XOR-of-payload byte.
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   start          in   1   one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid     in   1   upstream byte present
//   byte_data      in   8   upstream byte
//   byte_ready     out  1   loader takes a byte this cycle
//   ext_memwrite   out  1   external memory write strobe (Ext_MemWrite)
//   ext_writedata  out  32  external write data (Ext_WriteData)
//   ext_dataadr    out  32  external byte address (Ext_DataAdr)
//   cpu_reset      out  1   active-high CPU hold
//   busy           out  1   load in progress
//   done           out  1   image loaded and verified
//   error          out  1   load failed (oversize header or bad checksum)
//   words_written  out  16  words committed in the current load
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        ext_memwrite,
   output logic [31:0] ext_writedata,
   output logic [31:0] ext_dataadr,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_written
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] word_q, word_d;

   logic        byte_ready_q, byte_ready_d;
   logic        memwrite_q, memwrite_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] adr_q, adr_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [15:0] ww_q, ww_d;

   logic        accept;
   logic [15:0] len_full;

   // Handshake is evaluated against the registered ready, so a byte offered
   // during WRITE simply waits until the next DATA/CSUM cycle.
   assign accept   = byte_valid && byte_ready_q;
   assign len_full = {byte_data, len_q[7:0]};

   // Next-state and datapath. Every control output is derived from state_d so
   // that the registered outputs line up with the state they describe.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      len_d      = len_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      csum_d     = csum_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      adr_d      = adr_q;
      ww_d       = ww_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LEN0;
               byte_idx_d = 2'd0;
               word_idx_d = 16'd0;
               csum_d     = 8'd0;
               ww_d       = 16'd0;
            end
         end

         S_LEN0: begin
            if (accept) begin
               len_d[7:0] = byte_data;
               state_d    = S_LEN1;
            end
         end

         S_LEN1: begin
            if (accept) begin
               len_d[15:8] = byte_data;
               if ({16'h0000, len_full} > MAX_WORDS) begin
                  state_d = S_ERR;
               end else if (len_full == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
               csum_d     = csum_q ^ byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  // Word complete: present it on the write port next cycle.
                  state_d = S_WRITE;
                  wdata_d = word_d;
                  adr_d   = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
               end
            end
         end

         S_WRITE: begin
            word_idx_d = word_idx_q + 16'd1;
            ww_d       = ww_q + 16'd1;
            state_d    = (word_idx_q + 16'd1 == len_q) ? S_CSUM : S_DATA;
         end

         S_CSUM: begin
            if (accept) begin
               state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
            end
         end

         default: state_d = S_IDLE;
      endcase

      byte_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CSUM);
      memwrite_d   = (state_d == S_WRITE);
      busy_d       = byte_ready_d || (state_d == S_WRITE);
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_ERR);
      // The CPU is released only in DONE; in particular it is always held
      // while a write is on the port.
      cpu_reset_d  = (state_d != S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         len_q        <= 16'd0;
         byte_idx_q   <= 2'd0;
         word_idx_q   <= 16'd0;
         csum_q       <= 8'd0;
         word_q       <= 32'd0;
         byte_ready_q <= 1'b0;
         memwrite_q   <= 1'b0;
         wdata_q      <= 32'd0;
         adr_q        <= BASE_ADDR;
         cpu_reset_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         ww_q         <= 16'd0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         byte_idx_q   <= byte_idx_d;
         word_idx_q   <= word_idx_d;
         csum_q       <= csum_d;
         word_q       <= word_d;
         byte_ready_q <= byte_ready_d;
         memwrite_q   <= memwrite_d;
         wdata_q      <= wdata_d;
         adr_q        <= adr_d;
         cpu_reset_q  <= cpu_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         ww_q         <= ww_d;
      end
   end

   assign byte_ready    = byte_ready_q;
   assign ext_memwrite  = memwrite_q;
   assign ext_writedata = wdata_q;
   assign ext_dataadr   = adr_q;
   assign cpu_reset     = cpu_reset_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_written = ww_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader: a table of complete frames with
// hand-computed expected writes and final status, followed by hand-written
// sequences for backpressure, a maximum-size image and reset mid-load.
// -----------------------------------------------------------------------------
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        ext_memwrite;
   logic [31:0] ext_writedata;
   logic [31:0] ext_dataadr;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int total = 0;
   int bad   = 0;

   logic [63:0] wq[$];   // observed writes as {address, data}

   typedef struct {
      int          nbytes;
      logic [7:0]  b[12];
      int          exp_writes;
      logic [31:0] wa[2];
      logic [31:0] wd[2];
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_ww;
   } vec_t;

   vec_t vecs[6];

   prog_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .ext_memwrite  (ext_memwrite),
      .ext_writedata (ext_writedata),
      .ext_dataadr   (ext_dataadr),
      .cpu_reset     (cpu_reset),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write monitor: records every write and confirms the CPU is held.
   always @(negedge clk) begin
      if (ext_memwrite === 1'b1) begin
         wq.push_back({ext_dataadr, ext_writedata});
         check("cpu_reset_during_write", {31'd0, cpu_reset}, 32'd1);
      end
   end

   // All tasks are entered and left at a falling edge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         byte_valid = 1'b0;
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("byte_ready_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);   // the rising edge in between took the byte
      end
      byte_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic check_status(input string tag, input logic e_done, input logic e_err,
                               input logic [15:0] e_ww);
      check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
      check({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
      check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~e_done});
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_words_written"}, {16'd0, words_written}, {16'd0, e_ww});
   endtask

   task automatic check_nominal_writes(input string tag);
      check({tag, "_nwrites"}, wq.size(), 32'd2);
      if (wq.size() >= 2) begin
         check({tag, "_w0"}, wq[0][63:32], 32'h0000_0000);
         check({tag, "_d0"}, wq[0][31:0], 32'h0050_0093);
         check({tag, "_w1"}, wq[1][63:32], 32'h0000_0004);
         check({tag, "_d1"}, wq[1][31:0], 32'h0010_0113);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_memwrite"}, {31'd0, ext_memwrite}, 32'd0);
      check({tag, "_writedata"}, ext_writedata, 32'd0);
      check({tag, "_dataadr"}, ext_dataadr, 32'h0000_0000);
      check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_error"}, {31'd0, error}, 32'd0);
      check({tag, "_ww"}, {16'd0, words_written}, 32'd0);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  nom[12];
      int          gaps[11];
      logic [7:0]  big[256];
      logic [7:0]  big_cs;

      nom = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'h10, 8'h00, 8'hC1, 8'h00};

      // 0: nominal two-word image
      vecs[0].nbytes = 11; vecs[0].b = nom; vecs[0].exp_writes = 2;
      vecs[0].wa = '{32'h0, 32'h4}; vecs[0].wd = '{32'h0050_0093, 32'h0010_0113};
      vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0; vecs[0].exp_ww = 16'd2;
      // 1: zero length, good checksum
      vecs[1].nbytes = 3; vecs[1].b = '{default: 8'h00}; vecs[1].exp_writes = 0;
      vecs[1].wa = '{32'h0, 32'h0}; vecs[1].wd = '{32'h0, 32'h0};
      vecs[1].exp_done = 1'b1; vecs[1].exp_err = 1'b0; vecs[1].exp_ww = 16'd0;
      // 2: zero length, bad checksum
      vecs[2] = vecs[1]; vecs[2].b[2] = 8'h01;
      vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1;
      // 3: oversize header, 65 words
      vecs[3] = vecs[1]; vecs[3].nbytes = 2; vecs[3].b[0] = 8'h41;
      vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1;
      // 4: nominal payload, wrong checksum
      vecs[4] = vecs[0]; vecs[4].b[10] = 8'hC0;
      vecs[4].exp_done = 1'b0; vecs[4].exp_err = 1'b1;
      // 5: restart from ERR with a correct image
      vecs[5] = vecs[0];

      reset      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      settle(3);
      check_reset_values("in_reset");
      reset = 1'b1;
      settle(2);
      check_reset_values("after_reset");

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         wq.delete();
         pulse_start();
         for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].b[i], 0);
         settle(3);
         check($sformatf("v%0d_nwrites", v), wq.size(), vecs[v].exp_writes);
         for (int i = 0; i < vecs[v].exp_writes && i < wq.size(); i++) begin
            check($sformatf("v%0d_addr%0d", v, i), wq[i][63:32], vecs[v].wa[i]);
            check($sformatf("v%0d_data%0d", v, i), wq[i][31:0], vecs[v].wd[i]);
         end
         check_status($sformatf("v%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_ww);
      end

      // Backpressure and gaps; bytes right after each 4th byte wait out WRITE.
      // start is held high mid-load and must be ignored.
      gaps = '{1, 2, 0, 1, 3, 0, 0, 1, 0, 2, 1};
      wq.delete();
      pulse_start();
      for (int i = 0; i < 11; i++) begin
         if (i == 5) start = 1'b1;
         send_byte(nom[i], gaps[i]);
         start = 1'b0;
      end
      settle(3);
      check_nominal_writes("bp");
      check_status("bp", 1'b1, 1'b0, 16'd2);

      // Largest legal image: MAX_WORDS = 64 words
      wq.delete();
      big_cs = 8'h00;
      for (int k = 0; k < 256; k++) begin
         big[k] = 8'(k * 7 + 1);
         big_cs = big_cs ^ big[k];
      end
      pulse_start();
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      for (int k = 0; k < 256; k++) send_byte(big[k], 0);
      send_byte(big_cs, 0);
      settle(3);
      check("max_nwrites", wq.size(), 32'd64);
      for (int i = 0; i < 64 && i < wq.size(); i++) begin
         check($sformatf("max_addr%0d", i), wq[i][63:32], 32'(i * 4));
         check($sformatf("max_data%0d", i), wq[i][31:0],
               {big[4*i+3], big[4*i+2], big[4*i+1], big[4*i]});
      end
      check_status("max", 1'b1, 1'b0, 16'd64);

      // Reset during the second word's DATA phase
      wq.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(nom[i], 0);
      check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check_reset_values("async_reset");
      settle(3);
      check("mid_nwrites", wq.size(), 32'd1);
      reset = 1'b1;
      settle(2);
      wq.delete();
      pulse_start();
      for (int i = 0; i < 11; i++) send_byte(nom[i], 0);
      settle(3);
      check_nominal_writes("post_reset");
      check_status("post_reset", 1'b1, 1'b0, 16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
